// File: rtl/msi_write_scheduler_pkg.sv
// Shared SoC constants for the IMSIC window and the MSI write scheduler state encoding.
package msi_write_scheduler_pkg;

  localparam logic [63:0] IMSICBase       = 64'h2400_0000;
  localparam logic [63:0] IMSICLength     = 64'h0000_4000;
  localparam int unsigned NrIntpFiles     = 3;
  localparam int unsigned NrSourcesW      = 5;
  localparam logic [63:0] ImsicFileStride = 64'h1000;
  localparam int unsigned DefaultNrReq    = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP,
    DONE
  } sched_state_t;

endpackage

// File: rtl/msi_write_scheduler_if.sv
// Requester handshake plus AXI-style AW/W/B channels seen by the MSI write scheduler.
interface msi_write_scheduler_if #(
  parameter int unsigned NrReq      = msi_write_scheduler_pkg::DefaultNrReq,
  parameter int unsigned FileW      = 2,
  parameter int unsigned NrSourcesW = msi_write_scheduler_pkg::NrSourcesW
);
  logic [NrReq-1:0]                  req_valid_i;
  logic [NrReq-1:0]                  req_ready_o;
  logic [NrReq-1:0][FileW-1:0]       req_file_i;
  logic [NrReq-1:0][NrSourcesW-1:0]  req_eiid_i;
  logic [NrReq-1:0]                  done_o;
  logic [NrReq-1:0]                  err_o;
  logic                              aw_valid_o;
  logic                              aw_ready_i;
  logic [63:0]                       aw_addr_o;
  logic                              w_valid_o;
  logic                              w_ready_i;
  logic [31:0]                       w_data_o;
  logic [3:0]                        w_strb_o;
  logic                              b_valid_i;
  logic                              b_ready_o;
  logic [1:0]                        b_resp_i;
  logic                              busy_o;

  // master: the scheduler; slave: requesters plus crossbar
  modport master (
    input  req_valid_i, req_file_i, req_eiid_i, aw_ready_i, w_ready_i, b_valid_i, b_resp_i,
    output req_ready_o, done_o, err_o, aw_valid_o, aw_addr_o, w_valid_o, w_data_o, w_strb_o,
           b_ready_o, busy_o
  );

  modport slave (
    output req_valid_i, req_file_i, req_eiid_i, aw_ready_i, w_ready_i, b_valid_i, b_resp_i,
    input  req_ready_o, done_o, err_o, aw_valid_o, aw_addr_o, w_valid_o, w_data_o, w_strb_o,
           b_ready_o, busy_o
  );
endinterface

// File: rtl/msi_rr_picker.sv
// Combinational round-robin picker: first requester after last (mod NrReq) wins.
module msi_rr_picker #(
  parameter int unsigned NrReq = 3,
  localparam int unsigned IdxW = (NrReq > 1) ? $clog2(NrReq) : 1
) (
  input  logic [NrReq-1:0] req,
  input  logic [IdxW-1:0]  last,
  output logic [NrReq-1:0] gnt,
  output logic [IdxW-1:0]  idx
);
  logic found;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= int'(NrReq); k++) begin
      if (!found && req[(int'(last) + k) % int'(NrReq)]) begin
        found = 1'b1;
        idx   = IdxW'((int'(last) + k) % int'(NrReq));
      end
    end
  end

  for (genvar gi = 0; gi < int'(NrReq); gi++) begin : g_gnt
    assign gnt[gi] = found && (idx == IdxW'(gi));
  end

endmodule

// File: rtl/msi_write_scheduler.sv
// Serialises MSI requests into single 32-bit writes to the IMSIC seteipnum_le registers.
module msi_write_scheduler
  import msi_write_scheduler_pkg::*;
#(
  parameter int unsigned NrReq       = msi_write_scheduler_pkg::DefaultNrReq,
  parameter int unsigned NrIntpFiles = msi_write_scheduler_pkg::NrIntpFiles,
  parameter int unsigned FileW       = $clog2(NrIntpFiles),
  parameter int unsigned NrSourcesW  = msi_write_scheduler_pkg::NrSourcesW,
  parameter logic [63:0] ImsicBase   = msi_write_scheduler_pkg::IMSICBase,
  parameter logic [63:0] FileStride  = msi_write_scheduler_pkg::ImsicFileStride
) (
  input logic                  clk_i,
  input logic                  rst_i,
  msi_write_scheduler_if.master bus
);
  localparam int unsigned IdxW = (NrReq > 1) ? $clog2(NrReq) : 1;

  sched_state_t    state_reg, state_next;
  logic [IdxW-1:0] last_reg, last_next;
  logic [IdxW-1:0] gnt_idx_reg, gnt_idx_next;
  logic [63:0]     addr_reg, addr_next;
  logic [31:0]     data_reg, data_next;
  logic            err_reg, err_next;
  logic            aw_valid_reg, aw_valid_next;
  logic            w_valid_reg, w_valid_next;

  logic [NrReq-1:0]      pick_gnt;
  logic [IdxW-1:0]       pick_idx;
  logic [NrReq-1:0]      req_ready;
  logic [FileW-1:0]      sel_file;
  logic [NrSourcesW-1:0] sel_eiid;

  msi_rr_picker #(.NrReq(NrReq)) u_picker (
    .req  (bus.req_valid_i),
    .last (last_reg),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  assign sel_file = bus.req_file_i[pick_idx];
  assign sel_eiid = bus.req_eiid_i[pick_idx];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      last_reg     <= IdxW'(NrReq - 1);
      gnt_idx_reg  <= '0;
      addr_reg     <= '0;
      data_reg     <= '0;
      err_reg      <= 1'b0;
      aw_valid_reg <= 1'b0;
      w_valid_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      last_reg     <= last_next;
      gnt_idx_reg  <= gnt_idx_next;
      addr_reg     <= addr_next;
      data_reg     <= data_next;
      err_reg      <= err_next;
      aw_valid_reg <= aw_valid_next;
      w_valid_reg  <= w_valid_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    last_next     = last_reg;
    gnt_idx_next  = gnt_idx_reg;
    addr_next     = addr_reg;
    data_next     = data_reg;
    err_next      = err_reg;
    aw_valid_next = aw_valid_reg;
    w_valid_next  = w_valid_reg;
    req_ready     = '0;

    case (state_reg)
      IDLE: begin
        if (|bus.req_valid_i) begin
          req_ready    = pick_gnt;
          last_next    = pick_idx;
          gnt_idx_next = pick_idx;
          addr_next    = ImsicBase + 64'(sel_file) * FileStride;
          data_next    = 32'(sel_eiid);
          // Malformed requests complete with an error and never reach the bus
          if ((int'(sel_file) < int'(NrIntpFiles)) && (sel_eiid != '0)) begin
            err_next      = 1'b0;
            aw_valid_next = 1'b1;
            w_valid_next  = 1'b1;
            state_next    = ISSUE;
          end else begin
            err_next   = 1'b1;
            state_next = DONE;
          end
        end
      end
      ISSUE: begin
        if (bus.aw_ready_i) aw_valid_next = 1'b0;
        if (bus.w_ready_i)  w_valid_next  = 1'b0;
        if ((!aw_valid_reg || bus.aw_ready_i) && (!w_valid_reg || bus.w_ready_i)) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (bus.b_valid_i) begin
          err_next   = (bus.b_resp_i >= 2'b10);
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The grant is combinational, so mask it while reset holds the FSM in IDLE
  assign bus.req_ready_o = rst_i ? '0 : req_ready;

  for (genvar gi = 0; gi < int'(NrReq); gi++) begin : g_done
    assign bus.done_o[gi] = (state_reg == DONE) && (gnt_idx_reg == IdxW'(gi));
    assign bus.err_o[gi]  = bus.done_o[gi] && err_reg;
  end

  assign bus.aw_valid_o = aw_valid_reg;
  assign bus.aw_addr_o  = aw_valid_reg ? addr_reg : '0;
  assign bus.w_valid_o  = w_valid_reg;
  assign bus.w_data_o   = w_valid_reg ? data_reg : '0;
  assign bus.w_strb_o   = w_valid_reg ? 4'hF : 4'h0;
  assign bus.b_ready_o  = (state_reg == RESP);
  assign bus.busy_o     = (state_reg != IDLE);

endmodule

// File: tb/tb_msi_write_scheduler.sv
// Directed bench for msi_write_scheduler: fairness, skew, error paths and mid-transaction reset.
module tb_msi_write_scheduler;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  msi_write_scheduler_if #(.NrReq(3), .FileW(2), .NrSourcesW(5)) bus ();

  msi_write_scheduler dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Called at a negedge with requests already driven; returns at the negedge showing done
  task automatic run_txn(input string tag, input logic [2:0] exp_gnt, input logic [2:0] exp_err);
    int   n;
    logic got;
    n = 0;
    #1;
    while (bus.req_ready_o == 3'b000 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq({tag, "_gnt"}, 64'(bus.req_ready_o), 64'(exp_gnt));
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      bus.b_valid_i = bus.b_ready_o;
      if (|bus.done_o) begin
        got = 1'b1;
        check_eq({tag, "_done"}, 64'(bus.done_o), 64'(exp_gnt));
        check_eq({tag, "_err"}, 64'(bus.err_o), 64'(exp_err));
      end
    end
    if (!got) check_eq({tag, "_timeout"}, 64'(got), 64'(1'b1));
    bus.b_valid_i = 1'b0;
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst             = 1'b1;
    bus.req_valid_i = '0;
    bus.req_file_i  = '0;
    bus.req_eiid_i  = '0;
    bus.aw_ready_i  = 1'b1;
    bus.w_ready_i   = 1'b1;
    bus.b_valid_i   = 1'b0;
    bus.b_resp_i    = 2'b00;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 64'(bus.req_ready_o), 64'd0);
    check_eq("rst_done", 64'(bus.done_o), 64'd0);
    check_eq("rst_awvalid", 64'(bus.aw_valid_o), 64'd0);
    check_eq("rst_addr", bus.aw_addr_o, 64'd0);
    check_eq("rst_bready", 64'(bus.b_ready_o), 64'd0);
    check_eq("rst_busy", 64'(bus.busy_o), 64'd0);
    rst = 1'b0;

    // Fairness: all three held valid
    for (int i = 0; i < 3; i++) begin
      bus.req_file_i[i] = 2'(i);
      bus.req_eiid_i[i] = 5'(i + 1);
    end
    bus.req_valid_i = 3'b111;
    run_txn("rr0", 3'b001, 3'b000);
    run_txn("rr1", 3'b010, 3'b000);
    run_txn("rr2", 3'b100, 3'b000);
    run_txn("rr3", 3'b001, 3'b000);
    run_txn("rr4", 3'b010, 3'b000);
    run_txn("rr5", 3'b100, 3'b000);
    bus.req_valid_i = '0;
    @(negedge clk);

    // Single request, best case
    bus.req_valid_i   = 3'b001;
    bus.req_file_i[0] = 2'd1;
    bus.req_eiid_i[0] = 5'd5;
    #1;
    check_eq("single_ready", 64'(bus.req_ready_o), 64'h1);
    @(negedge clk);
    bus.req_valid_i = '0;
    check_eq("single_awvalid", 64'(bus.aw_valid_o), 64'h1);
    check_eq("single_wvalid", 64'(bus.w_valid_o), 64'h1);
    check_eq("single_addr", bus.aw_addr_o, 64'h2400_1000);
    check_eq("single_data", 64'(bus.w_data_o), 64'h5);
    check_eq("single_strb", 64'(bus.w_strb_o), 64'hF);
    @(negedge clk);
    check_eq("single_awdrop", 64'(bus.aw_valid_o), 64'h0);
    check_eq("single_bready", 64'(bus.b_ready_o), 64'h1);
    bus.b_valid_i = 1'b1;
    bus.b_resp_i  = 2'b00;
    @(negedge clk);
    bus.b_valid_i = 1'b0;
    check_eq("single_done", 64'(bus.done_o), 64'h1);
    check_eq("single_err", 64'(bus.err_o), 64'h0);
    @(negedge clk);
    check_eq("single_done_clr", 64'(bus.done_o), 64'h0);
    check_eq("single_idle", 64'(bus.busy_o), 64'h0);

    // Channel skew plus SLVERR response
    bus.aw_ready_i    = 1'b0;
    bus.w_ready_i     = 1'b0;
    bus.req_valid_i   = 3'b001;
    bus.req_file_i[0] = 2'd2;
    bus.req_eiid_i[0] = 5'd31;
    #1;
    check_eq("skew_ready", 64'(bus.req_ready_o), 64'h1);
    @(negedge clk);
    bus.req_valid_i = '0;
    bus.aw_ready_i  = 1'b1;
    check_eq("skew_addr", bus.aw_addr_o, 64'h2400_2000);
    @(negedge clk);
    bus.aw_ready_i = 1'b0;
    check_eq("skew_awdrop", 64'(bus.aw_valid_o), 64'h0);
    check_eq("skew_whold2", 64'(bus.w_valid_o), 64'h1);
    check_eq("skew_data2", 64'(bus.w_data_o), 64'd31);
    @(negedge clk);
    check_eq("skew_data3", 64'(bus.w_data_o), 64'd31);
    check_eq("skew_bready3", 64'(bus.b_ready_o), 64'h0);
    @(negedge clk);
    bus.w_ready_i = 1'b1;
    check_eq("skew_whold4", 64'(bus.w_valid_o), 64'h1);
    @(negedge clk);
    bus.w_ready_i = 1'b0;
    check_eq("skew_wdrop", 64'(bus.w_valid_o), 64'h0);
    check_eq("skew_bready5", 64'(bus.b_ready_o), 64'h1);
    bus.b_valid_i = 1'b1;
    bus.b_resp_i  = 2'b10;
    @(negedge clk);
    bus.b_valid_i = 1'b0;
    bus.b_resp_i  = 2'b00;
    check_eq("slverr_done", 64'(bus.done_o), 64'h1);
    check_eq("slverr_err", 64'(bus.err_o), 64'h1);
    @(negedge clk);
    bus.aw_ready_i = 1'b1;
    bus.w_ready_i  = 1'b1;

    // Invalid file on requester 1
    bus.req_valid_i   = 3'b010;
    bus.req_file_i[1] = 2'd3;
    bus.req_eiid_i[1] = 5'd7;
    #1;
    check_eq("badfile_ready", 64'(bus.req_ready_o), 64'h2);
    @(negedge clk);
    bus.req_valid_i = '0;
    check_eq("badfile_done", 64'(bus.done_o), 64'h2);
    check_eq("badfile_err", 64'(bus.err_o), 64'h2);
    check_eq("badfile_noaw", 64'(bus.aw_valid_o), 64'h0);
    @(negedge clk);
    check_eq("badfile_clr", 64'(bus.done_o), 64'h0);

    // Zero EIID on requester 2
    bus.req_valid_i   = 3'b100;
    bus.req_file_i[2] = 2'd0;
    bus.req_eiid_i[2] = 5'd0;
    #1;
    check_eq("eiid0_ready", 64'(bus.req_ready_o), 64'h4);
    @(negedge clk);
    bus.req_valid_i = '0;
    check_eq("eiid0_done", 64'(bus.done_o), 64'h4);
    check_eq("eiid0_err", 64'(bus.err_o), 64'h4);
    check_eq("eiid0_now", 64'(bus.w_valid_o), 64'h0);
    @(negedge clk);

    // Reset while waiting for B
    bus.req_valid_i   = 3'b100;
    bus.req_eiid_i[2] = 5'd1;
    #1;
    check_eq("rstmid_ready", 64'(bus.req_ready_o), 64'h4);
    @(negedge clk);
    @(negedge clk);
    check_eq("rstmid_bready", 64'(bus.b_ready_o), 64'h1);
    rst = 1'b1;
    #1;
    check_eq("rstmid_bready0", 64'(bus.b_ready_o), 64'h0);
    check_eq("rstmid_busy0", 64'(bus.busy_o), 64'h0);
    check_eq("rstmid_ready0", 64'(bus.req_ready_o), 64'h0);
    check_eq("rstmid_done0", 64'(bus.done_o), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.req_file_i[i] = 2'(i);
      bus.req_eiid_i[i] = 5'(i + 1);
    end
    bus.req_valid_i = 3'b111;
    run_txn("post_rst", 3'b001, 3'b000);
    bus.req_valid_i = '0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
